// File: rtl/regfile_snapshot_loader.sv
// -----------------------------------------------------------------------------
// regfile_snapshot_loader
//
// Assembles one NREGS*W-bit register snapshot from a stream of W-bit words,
// one word per valid/ready handshake. The words arrive in trace order: eax
// first, eflags last. Each accepted word is shifted in at the bottom, so the
// first word ends up in the top slice. The completed snapshot is held on
// raw_regs until the consumer accepts it. Frames of the wrong length raise a
// one-cycle err pulse. The loader then resynchronises on the next frame.
//
// Ports
//   clk        in   1         single clock, rising edge
//   rst_n      in   1         asynchronous assert, active-low reset
//   in_valid   in   1         in_word / in_last are valid
//   in_ready   out  1         loader accepts a word this cycle (state only)
//   in_word    in   W         next register value
//   in_last    in   1         final word of a frame
//   out_valid  out  1         raw_regs holds a complete snapshot
//   out_ready  in   1         consumer takes the snapshot
//   raw_regs   out  NREGS*W   snapshot; eax in the top W bits, eflags at [W-1:0]
//   err        out  1         one-cycle pulse on a frame-length error
//   frames     out  16        delivered snapshot count, wraps
// -----------------------------------------------------------------------------
module regfile_snapshot_loader #(
    parameter int NREGS = 10,
    parameter int W     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         in_word,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NREGS*W-1:0]   raw_regs,
    output logic                 err,
    output logic [15:0]          frames
);

    localparam int CNT_W = $clog2(NREGS);
    localparam int SNAP_W = NREGS * W;

    typedef enum logic [1:0] {
        ST_FILL    = 2'd0,
        ST_FULL    = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [SNAP_W-1:0]   raw_q;
    logic                out_valid_q;
    logic                err_q;
    logic [15:0]         frames_q;

    logic                accept;
    logic                cnt_at_end;
    logic [SNAP_W-1:0]   raw_shift_d;

    // Ready depends only on the registered state, never on in_valid. A
    // pending snapshot blocks the input because there is only one buffer.
    assign in_ready    = (state_q != ST_FULL);
    assign accept      = in_valid && in_ready;
    assign cnt_at_end  = (cnt_q == CNT_W'(NREGS - 1));
    // The newest word enters at the bottom, so the first word (eax) ends in the top slice.
    assign raw_shift_d = {raw_q[SNAP_W-W-1:0], in_word};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FILL;
            cnt_q       <= '0;
            raw_q       <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            frames_q    <= '0;
        end else begin
            err_q <= 1'b0;
            unique case (state_q)
                ST_FILL: begin
                    if (accept) begin
                        // Shift on every accepted word. A frame that is
                        // abandoned leaves junk here. That is harmless
                        // because raw_regs is only meaningful when
                        // out_valid is high.
                        raw_q <= raw_shift_d;
                        if (cnt_at_end) begin
                            cnt_q <= '0;
                            if (in_last) begin
                                state_q     <= ST_FULL;
                                out_valid_q <= 1'b1;
                            end else begin
                                // Long frame: drop the rest up to its in_last.
                                err_q   <= 1'b1;
                                state_q <= ST_DISCARD;
                            end
                        end else if (in_last) begin
                            // Short frame: the next word begins a fresh frame.
                            err_q <= 1'b1;
                            cnt_q <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        state_q     <= ST_FILL;
                        out_valid_q <= 1'b0;
                        frames_q    <= frames_q + 16'd1;
                    end
                end
                ST_DISCARD: begin
                    if (accept && in_last) begin
                        state_q <= ST_FILL;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= ST_FILL;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign raw_regs  = raw_q;
    assign err       = err_q;
    assign frames    = frames_q;

endmodule
